// File: rtl/int_timer.sv
// rtl/int_timer.sv - 16-bit programmable interval timer with byte-wide register bus and level interrupt
module int_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs,
    input  logic       rwb,
    input  logic [2:0] addr,
    input  logic [7:0] i_data,
    output logic [7:0] o_data,
    output logic       int_out
);
    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_STATUS = 3'd1;
    localparam logic [2:0] A_RLO    = 3'd2;
    localparam logic [2:0] A_RHI    = 3'd3;
    localparam logic [2:0] A_CLO    = 3'd4;
    localparam logic [2:0] A_CHI    = 3'd5;

    logic        en_q, en_d, per_q, per_d, ie_q, ie_d, if_q, if_d;
    logic [1:0]  presc_q, presc_d;
    logic [15:0] reload_q, reload_d, count_q, count_d;
    logic [7:0]  stage_q, stage_d, shadow_q, shadow_d, pcnt_q, pcnt_d;

    logic wr, rd, wr_ctrl, commit, en_rise, per_eff, tick, expire;

    assign wr      = cs & ~rwb;
    assign rd      = cs & rwb;
    assign wr_ctrl = wr && (addr == A_CTRL);
    assign commit  = wr && (addr == A_RHI);
    assign en_rise = wr_ctrl && i_data[0] && !en_q;
    // A CTRL write on the expiry edge decides whether that expiry reloads.
    assign per_eff = wr_ctrl ? i_data[1] : per_q;

    always_comb begin
        case (presc_q)
            2'b00:   tick = en_q;
            2'b01:   tick = en_q && (pcnt_q[2:0] == 3'h7);
            2'b10:   tick = en_q && (pcnt_q[5:0] == 6'h3f);
            default: tick = en_q && (pcnt_q == 8'hff);
        endcase
    end

    assign expire = tick && (count_q == 16'h0000);

    always_comb begin
        en_d     = en_q;
        per_d    = per_q;
        ie_d     = ie_q;
        presc_d  = presc_q;
        if_d     = if_q;
        reload_d = reload_q;
        stage_d  = stage_q;
        count_d  = count_q;
        shadow_d = shadow_q;
        pcnt_d   = pcnt_q;

        if (wr_ctrl) begin
            en_d    = i_data[0];
            per_d   = i_data[1];
            ie_d    = i_data[2];
            presc_d = i_data[5:4];
        end
        if (wr && (addr == A_STATUS) && i_data[0]) if_d = 1'b0;
        if (wr && (addr == A_RLO)) stage_d = i_data;
        if (rd && (addr == A_CLO)) shadow_d = count_q[15:8];

        if (en_q) pcnt_d = pcnt_q + 8'd1;
        if (tick) begin
            if (expire) begin
                if_d = 1'b1;
                if (per_eff) begin
                    count_d = reload_q;
                end else begin
                    count_d = 16'h0000;
                    en_d    = 1'b0;
                end
            end else begin
                count_d = count_q - 16'd1;
            end
        end
        if (en_rise) begin
            count_d = reload_q;
            pcnt_d  = 8'h00;
        end
        // The commit overrides any expiry reload on the same edge; IF is unaffected.
        if (commit) begin
            reload_d = {i_data, stage_q};
            count_d  = {i_data, stage_q};
            pcnt_d   = 8'h00;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_q     <= 1'b0;
            per_q    <= 1'b0;
            ie_q     <= 1'b0;
            presc_q  <= 2'b00;
            if_q     <= 1'b0;
            reload_q <= 16'hffff;
            stage_q  <= 8'hff;
            count_q  <= 16'hffff;
            shadow_q <= 8'h00;
            pcnt_q   <= 8'h00;
        end else begin
            en_q     <= en_d;
            per_q    <= per_d;
            ie_q     <= ie_d;
            presc_q  <= presc_d;
            if_q     <= if_d;
            reload_q <= reload_d;
            stage_q  <= stage_d;
            count_q  <= count_d;
            shadow_q <= shadow_d;
            pcnt_q   <= pcnt_d;
        end
    end

    always_comb begin
        o_data = 8'h00;
        if (rd) begin
            case (addr)
                A_CTRL:   o_data = {2'b00, presc_q, 1'b0, ie_q, per_q, en_q};
                A_STATUS: o_data = {7'b0, if_q};
                A_RLO:    o_data = stage_q;
                A_RHI:    o_data = reload_q[15:8];
                A_CLO:    o_data = count_q[7:0];
                A_CHI:    o_data = shadow_q;
                default:  o_data = 8'h00;
            endcase
        end
    end

    assign int_out = if_q & ie_q;

endmodule
